// File: rtl/ssp_word_framer_if.sv
// Byte handshake bundle between the SSP word framer and its local client:
// a transmit holding-register handshake and a receive byte strobe.
interface ssp_word_framer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  rx_data,
    input  rx_valid
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output rx_data,
    output rx_valid
  );
endinterface

// File: rtl/ssp_word_framer.sv
// Byte-wide SSP link layer: MSB-first serialiser with generated ssp_clk/ssp_frame
// and a frame-aligned receive capture. Optional macro: SSP_TEST_PATTERN_EN.
module ssp_word_framer #(
  parameter int          HALF_PERIOD = 4,
  parameter logic [31:0] PATTERN     = 32'hDEADBEEF
) (
  input  logic               ck_1356meg,
  input  logic               rst,
  ssp_word_framer_if.slave   bus,
  input  logic               test_mode_i,
  output logic               busy_o,
  output logic               ssp_clk_o,
  output logic               ssp_frame_o,
  output logic               ssp_din_o,
  input  logic               ssp_dout_i
);

  // state | meaning
  // IDLE  | no word in flight, ssp_din/ssp_frame held low
  // SHIFT | word in flight, one bit per ssp_clk period
  typedef enum logic {IDLE, SHIFT} state_t;

  localparam int DW = $clog2(HALF_PERIOD);

  state_t        state_q;
  logic [DW-1:0] div_q, div_d;
  logic          ssp_clk_q;
  logic [7:0]    hold_q;
  logic          hold_full_q;
  logic [7:0]    shift_q;
  logic [2:0]    bit_cnt_q;
  logic          din_q;
  logic          frame_q;
  logic          busy_q;
  logic [7:0]    rx_shift_q;
  logic [7:0]    rx_data_q;
  logic          rx_valid_q;

  logic          tc, rise_evt, fall_evt;
  logic          boundary, start;
  logic          word_avail;
  logic [7:0]    word_next;
  logic          tx_ready;

`ifdef SSP_TEST_PATTERN_EN
  logic [31:0]   pat_q;

  assign word_avail = test_mode_i | hold_full_q;
  assign word_next  = test_mode_i ? pat_q[31:24] : hold_q;
  assign tx_ready   = ~hold_full_q & ~test_mode_i;
`else
  logic          unused_test_mode;
  logic [31:0]   unused_pattern;

  assign unused_test_mode = test_mode_i;
  assign unused_pattern   = PATTERN;
  assign word_avail       = hold_full_q;
  assign word_next        = hold_q;
  assign tx_ready         = ~hold_full_q;
`endif

  always_comb begin
    tc       = (div_q == DW'(HALF_PERIOD - 1));
    div_d    = tc ? '0 : div_q + DW'(1);
    rise_evt = tc & ~ssp_clk_q;
    fall_evt = tc &  ssp_clk_q;
    // Words start or end only on a fall, so data is stable across every rise.
    boundary = fall_evt & ((state_q == IDLE) | (bit_cnt_q == 3'd0));
    start    = boundary & word_avail;
  end

  always_ff @(posedge ck_1356meg) begin
    if (rst) begin
      state_q     <= IDLE;
      div_q       <= '0;
      ssp_clk_q   <= 1'b0;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      shift_q     <= 8'h00;
      bit_cnt_q   <= 3'd0;
      din_q       <= 1'b0;
      frame_q     <= 1'b0;
      busy_q      <= 1'b0;
      rx_shift_q  <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
`ifdef SSP_TEST_PATTERN_EN
      pat_q       <= PATTERN;
`endif
    end else begin
      div_q      <= div_d;
      rx_valid_q <= 1'b0;
      if (tc) ssp_clk_q <= ~ssp_clk_q;

      if (bus.tx_valid && tx_ready) begin
        hold_q      <= bus.tx_data;
        hold_full_q <= 1'b1;
      end

`ifdef SSP_TEST_PATTERN_EN
      if (!test_mode_i) pat_q <= PATTERN;
`endif

      if (start) begin
        shift_q   <= word_next;
        din_q     <= word_next[7];
        frame_q   <= 1'b1;
        bit_cnt_q <= 3'd7;
        busy_q    <= 1'b1;
        state_q   <= SHIFT;
`ifdef SSP_TEST_PATTERN_EN
        if (test_mode_i) pat_q <= {pat_q[23:0], pat_q[31:24]};
        else             hold_full_q <= 1'b0;
`else
        hold_full_q <= 1'b0;
`endif
      end else if (boundary) begin
        din_q   <= 1'b0;
        frame_q <= 1'b0;
        busy_q  <= 1'b0;
        state_q <= IDLE;
      end else if (fall_evt) begin
        shift_q   <= {shift_q[6:0], 1'b0};
        din_q     <= shift_q[6];
        frame_q   <= 1'b0;
        bit_cnt_q <= bit_cnt_q - 3'd1;
      end

      if (state_q == SHIFT && rise_evt) begin
        rx_shift_q <= {rx_shift_q[6:0], ssp_dout_i};
        if (bit_cnt_q == 3'd0) begin
          rx_data_q  <= {rx_shift_q[6:0], ssp_dout_i};
          rx_valid_q <= 1'b1;
        end
      end
    end
  end

  assign bus.tx_ready = tx_ready;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign busy_o       = busy_q;
  assign ssp_clk_o    = ssp_clk_q;
  assign ssp_frame_o  = frame_q;
  assign ssp_din_o    = din_q;

endmodule

// File: tb/tb_ssp_word_framer.sv
// Scoreboard bench for ssp_word_framer: random byte traffic in both directions,
// an ARM-side serial model, and directed reset / back-to-back / pattern cases.
`timescale 1ns/1ps
module tb_ssp_word_framer;
  localparam int HP = 4;

  logic ck = 1'b0;
  logic rst = 1'b1;
  logic test_mode = 1'b0;
  logic busy, ssp_clk, ssp_frame, ssp_din;
  logic ssp_dout = 1'b0;

  ssp_word_framer_if bus();

  ssp_word_framer #(.HALF_PERIOD(HP), .PATTERN(32'hDEADBEEF)) dut (
    .ck_1356meg (ck),
    .rst        (rst),
    .bus        (bus),
    .test_mode_i(test_mode),
    .busy_o     (busy),
    .ssp_clk_o  (ssp_clk),
    .ssp_frame_o(ssp_frame),
    .ssp_din_o  (ssp_din),
    .ssp_dout_i (ssp_dout)
  );

  always #5 ck = ~ck;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];
  logic [7:0] arm_q[$];
  int         frame_at[$];

  task automatic chk_eq(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    vec_cnt++;
    err_cnt++;
    $display("FAIL %s: bound expired", nm);
  endtask

  // Monitor: serial scoreboard plus the ARM-side ssp_dout driver.
  logic       prev_clk = 1'b0;
  int         bits_n = 0;
  logic [7:0] sh = 8'h00;
  int         rise_cnt = 0;
  int         frames_seen = 0;
  int         frame_run = 0;
  logic [7:0] arm_byte = 8'h00;
  int         arm_idx = 0;

  always @(negedge ck) begin
    if (rst) begin
      tx_exp.delete();
      rx_exp.delete();
      bits_n    = 0;
      frame_run = 0;
      prev_clk  = 1'b0;
      arm_idx   = 0;
      ssp_dout  = 1'b0;
    end else begin
      if (ssp_frame) frame_run++;
      else if (frame_run != 0) begin
        chk_eq("frame_width", frame_run, 2 * HP);
        frame_run = 0;
      end

      if (ssp_clk && !prev_clk) begin
        if (ssp_frame) begin
          if (bits_n != 0) chk_eq("frame_early_bits", bits_n, 0);
          bits_n = 1;
          sh = {7'h00, ssp_din};
          frames_seen++;
          frame_at.push_back(rise_cnt);
        end else if (bits_n != 0) begin
          sh = {sh[6:0], ssp_din};
          bits_n++;
          chk_eq("busy_in_word", busy, 1);
        end else begin
          chk_eq("idle_din", ssp_din, 0);
        end
        if (bits_n == 8) begin
          if (tx_exp.size() == 0) chk_eq("tx_unexpected_word", sh, 32'hFFFF);
          else chk_eq("tx_word", sh, tx_exp.pop_front());
          bits_n = 0;
        end
        rise_cnt++;
      end

      if (!ssp_clk && prev_clk) begin
        if (ssp_frame) begin
          arm_byte = (arm_q.size() != 0) ? arm_q.pop_front() : 8'($urandom);
          rx_exp.push_back(arm_byte);
          arm_idx  = 7;
          ssp_dout = arm_byte[7];
        end else if (arm_idx > 0) begin
          arm_idx--;
          ssp_dout = arm_byte[arm_idx];
        end else begin
          ssp_dout = 1'($urandom);
        end
      end

      if (bus.rx_valid) begin
        if (rx_exp.size() == 0) chk_eq("rx_unexpected", bus.rx_data, 32'hFFFF);
        else chk_eq("rx_data", bus.rx_data, rx_exp.pop_front());
      end
      prev_clk = ssp_clk;
    end
  end

  task automatic send(input logic [7:0] b);
    int n = 0;
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    while (!bus.tx_ready && n < 500) begin
      @(negedge ck);
      n++;
    end
    if (!bus.tx_ready) begin
      fail_now("send_timeout");
      return;
    end
    tx_exp.push_back(b);
    @(negedge ck);
    chk_eq("tx_ready_full", bus.tx_ready, 0);
  endtask

  task automatic drop_valid();
    bus.tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int quiet = 0;
    int n = 0;
    while (quiet < 5 * HP && n < 5000) begin
      @(negedge ck);
      n++;
      if (busy) quiet = 0;
      else quiet++;
    end
    if (quiet < 5 * HP) fail_now("idle_timeout");
  endtask

  task automatic check_reset_outputs(input string tag);
    chk_eq({tag, "_ssp_clk"}, ssp_clk, 0);
    chk_eq({tag, "_ssp_frame"}, ssp_frame, 0);
    chk_eq({tag, "_ssp_din"}, ssp_din, 0);
    chk_eq({tag, "_rx_data"}, bus.rx_data, 0);
    chk_eq({tag, "_rx_valid"}, bus.rx_valid, 0);
    chk_eq({tag, "_busy"}, busy, 0);
    chk_eq({tag, "_tx_ready"}, bus.tx_ready, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;
    repeat (3) @(negedge ck);
    check_reset_outputs("por");
    rst = 1'b0;
    @(negedge ck);

    // Single word, MSB first, then line returns to idle.
    send(8'hA5);
    drop_valid();
    wait_idle();
    chk_eq("a5_idle_din", ssp_din, 0);
    chk_eq("a5_idle_frame", ssp_frame, 0);

    // Back-to-back words: frames exactly 8 bit periods apart.
    send(8'h12);
    send(8'h34);
    drop_valid();
    wait_idle();
    if (frame_at.size() >= 2)
      chk_eq("b2b_gap", frame_at[frame_at.size()-1] - frame_at[frame_at.size()-2], 8);
    else
      fail_now("b2b_frames");

    // Receive a known byte while sending zero.
    arm_q.push_back(8'h3C);
    send(8'h00);
    drop_valid();
    wait_idle();
    chk_eq("rx_3c_last", bus.rx_data, 8'h3C);

    // Three words offered while shifting.
    send(8'h81);
    send(8'h7E);
    send(8'hC3);
    drop_valid();
    wait_idle();

    // Random traffic with random gaps.
    for (int i = 0; i < 40; i++) begin
`ifndef SSP_TEST_PATTERN_EN
      test_mode = 1'($urandom);
`endif
      send(8'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        drop_valid();
        repeat ($urandom_range(1, 30)) @(negedge ck);
      end
    end
    drop_valid();
    test_mode = 1'b0;
    wait_idle();

    // Reset mid-word with the holding register full.
    send(8'hF0);
    send(8'h0F);
    drop_valid();
    n = 0;
    while (bits_n != 4 && n < 500) begin
      @(negedge ck);
      n++;
    end
    if (bits_n != 4) fail_now("reach_bit4");
    rst = 1'b1;
    @(negedge ck);
    check_reset_outputs("midrst");
    @(negedge ck);
    rst = 1'b0;
    repeat (40) @(negedge ck);
    chk_eq("post_rst_busy", busy, 0);
    send(8'h69);
    drop_valid();
    wait_idle();

`ifdef SSP_TEST_PATTERN_EN
    begin
      int base;
      tx_exp.push_back(8'hDE);
      tx_exp.push_back(8'hAD);
      tx_exp.push_back(8'hBE);
      tx_exp.push_back(8'hEF);
      tx_exp.push_back(8'hDE);
      base = frames_seen;
      test_mode = 1'b1;
      n = 0;
      while (frames_seen < base + 5 && n < 5000) begin
        @(negedge ck);
        n++;
      end
      if (frames_seen < base + 5) fail_now("pattern_frames");
      chk_eq("pattern_tx_ready", bus.tx_ready, 0);
      test_mode = 1'b0;
      wait_idle();
      tx_exp.push_back(8'hDE);
      tx_exp.push_back(8'hAD);
      base = frames_seen;
      test_mode = 1'b1;
      n = 0;
      while (frames_seen < base + 2 && n < 5000) begin
        @(negedge ck);
        n++;
      end
      if (frames_seen < base + 2) fail_now("pattern_restart");
      test_mode = 1'b0;
      wait_idle();
    end
`else
    test_mode = 1'b1;
    @(negedge ck);
    chk_eq("tm_ignored_ready", bus.tx_ready, 1);
    send(8'h5A);
    drop_valid();
    wait_idle();
    test_mode = 1'b0;
`endif

    chk_eq("tx_queue_drained", tx_exp.size(), 0);
    chk_eq("rx_queue_drained", rx_exp.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
